axi_lite_mem_arbiter: RTL and testbench

- 2-master to 1-slave AXI4-Lite arbiter.
- Shares the single SRAM AXI4-Lite slave between the IFU (M0, read-only) and the LSU (M1, read and write).
- Sits between the core's fetch/load-store units and the SRAM slave.
- Allows one transaction in flight at the slave. Grants are round-robin between the two masters and held until the response handshake completes.

---
 rtl/axi_lite_mem_arbiter_if.sv | 40 ++++
 rtl/axi_lite_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem_arbiter_if.sv
// AXI4-Lite bundle (AR/R/AW/W/B) shared by the fetch/LSU master ports and the SRAM slave port.
// The master modport drives requests. The slave modport drives responses.
interface axi_lite_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one SRAM AXI4-Lite slave arbiter.
// There is one transaction in flight. Grants are round-robin and are held until the R/B handshake.
module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axi_lite_mem_arbiter_if.slave   m0,
    axi_lite_mem_arbiter_if.slave   m1,
    axi_lite_mem_arbiter_if.master  s,
    output logic [1:0]              grant
);
    // The encoding doubles as the grant value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD0  = 2'b01,
        RD1  = 2'b10,
        WR1  = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;          // 0: M0 was granted last, 1: M1
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic              m1_req;
    logic              m1_wr;
    logic              rd_sel_m1;
    logic [ADDR_W-1:0] sel_araddr;
    logic              sel_arvalid;
    logic              sel_rready;
    logic [DATA_W-1:0] fwd_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        m0.arready = 1'b0;  m0.rdata = '0;  m0.rresp = 2'b00;  m0.rvalid = 1'b0;
        m0.awready = 1'b0;  m0.wready = 1'b0;  m0.bresp = 2'b00;  m0.bvalid = 1'b0;
        m1.arready = 1'b0;  m1.rdata = '0;  m1.rresp = 2'b00;  m1.rvalid = 1'b0;
        m1.awready = 1'b0;  m1.wready = 1'b0;  m1.bresp = 2'b00;  m1.bvalid = 1'b0;
        s.araddr   = '0;    s.arvalid = 1'b0;  s.rready = 1'b0;
        s.awaddr   = '0;    s.awvalid = 1'b0;
        s.wdata    = '0;    s.wstrb   = '0;    s.wvalid = 1'b0;
        s.bready   = 1'b0;

        m1_wr       = m1.awvalid | m1.wvalid;
        m1_req      = m1_wr | m1.arvalid;
        rd_sel_m1   = (state_q == RD1);
        sel_araddr  = rd_sel_m1 ? m1.araddr  : m0.araddr;
        sel_arvalid = rd_sel_m1 ? m1.arvalid : m0.arvalid;
        sel_rready  = rd_sel_m1 ? m1.rready  : m0.rready;
        fwd_rdata   = s.rdata;

        case (state_q)
            IDLE: begin
                // On a tie the master that was not granted last wins. M1 writes go before M1 reads.
                if (m0.arvalid && (!m1_req || last_q)) begin
                    state_d = RD0;
                    last_d  = 1'b0;
                end else if (m1_req) begin
                    state_d = m1_wr ? WR1 : RD1;
                    last_d  = 1'b1;
                end
            end
            RD0, RD1: begin
                s.araddr  = sel_araddr;
                s.arvalid = sel_arvalid & ~ar_done_q;
                s.rready  = sel_rready;
                if (rd_sel_m1) begin
                    m1.arready = s.arready & ~ar_done_q;
                    m1.rdata   = fwd_rdata;
                    m1.rresp   = s.rresp;
                    m1.rvalid  = s.rvalid;
                end else begin
                    m0.arready = s.arready & ~ar_done_q;
                    m0.rdata   = fwd_rdata;
                    m0.rresp   = s.rresp;
                    m0.rvalid  = s.rvalid;
                end
                if (sel_arvalid && s.arready && !ar_done_q) ar_done_d = 1'b1;
                if (s.rvalid && sel_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            WR1: begin
                // AW and W complete independently. B is passed through even if it arrives early.
                s.awaddr   = m1.awaddr;
                s.awvalid  = m1.awvalid & ~aw_done_q;
                m1.awready = s.awready & ~aw_done_q;
                s.wdata    = m1.wdata;
                s.wstrb    = m1.wstrb;
                s.wvalid   = m1.wvalid & ~w_done_q;
                m1.wready  = s.wready & ~w_done_q;
                s.bready   = m1.bready;
                m1.bresp   = s.bresp;
                m1.bvalid  = s.bvalid;
                if (m1.awvalid && s.awready && !aw_done_q) aw_done_d = 1'b1;
                if (m1.wvalid && s.wready && !w_done_q)    w_done_d  = 1'b1;
                if (s.bvalid && m1.bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        grant = state_q;
    end
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Bench for axi_lite_mem_arbiter: a behavioural SRAM slave, two scripted masters, and scoreboard queues of expected R/B results.
module tb_axi_lite_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    axi_lite_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    axi_lite_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();
    logic [1:0] grant;

    axi_lite_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if), .grant(grant)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  g;
        logic        r0hs, r1hs, bhs, m0_ar_rdy, s_arv, s_awv, s_wv;
        logic [31:0] r0d, r1d;
        logic [1:0]  bresp;
    } obs_t;
    obs_t obs[$];

    logic [31:0] exp_r0[$];
    logic [31:0] exp_r1[$];
    logic [1:0]  exp_b[$];
    int m0_reissue = 0;
    int m1_reissue = 0;

    // ---------------- behavioural SRAM slave ----------------
    int   rd_lat = 2;
    int   b_lat = 1;
    logic spur = 1'b0;
    logic [31:0] smem [16];
    logic rd_pend, aw_got, w_got, b_pend;
    int   rd_wait, b_wait;
    logic [31:0] rd_data, w_data_r;
    logic [3:0]  aw_idx, w_strb_r;

    function automatic logic [31:0] init_word(int i);
        return (i == 0) ? 32'h0000_0413 : (32'hC0DE_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] exp_rd(logic [31:0] a);
        return init_word(int'(a[5:2]));
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign s_if.arready = 1'b1;
    assign s_if.awready = 1'b1;
    assign s_if.wready  = 1'b1;
    assign s_if.rresp   = 2'b00;
    assign s_if.bresp   = 2'b00;
    assign s_if.rvalid  = (rd_pend && rd_wait == 0) | spur;
    assign s_if.rdata   = (rd_pend && rd_wait == 0) ? rd_data : 32'h0;
    assign s_if.bvalid  = (b_pend && b_wait == 0) | spur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) smem[i] <= init_word(i);
            rd_pend <= 1'b0; rd_wait <= 0; rd_data <= 32'h0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_idx <= 4'h0;
            w_data_r <= 32'h0; w_strb_r <= 4'h0; b_pend <= 1'b0; b_wait <= 0;
        end else begin
            if (s_if.arvalid && s_if.arready) begin
                rd_pend <= 1'b1;
                rd_wait <= rd_lat;
                rd_data <= smem[s_if.araddr[5:2]];
            end else if (rd_pend && rd_wait > 0) begin
                rd_wait <= rd_wait - 1;
            end else if (rd_pend && s_if.rready) begin
                rd_pend <= 1'b0;
            end
            if (s_if.awvalid && s_if.awready) begin
                aw_got <= 1'b1;
                aw_idx <= s_if.awaddr[5:2];
            end
            if (s_if.wvalid && s_if.wready) begin
                w_got    <= 1'b1;
                w_data_r <= s_if.wdata;
                w_strb_r <= s_if.wstrb;
            end
            if (aw_got && w_got) begin
                smem[aw_idx] <= merge(smem[aw_idx], w_data_r, w_strb_r);
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_pend <= 1'b1;
                b_wait <= b_lat;
            end else if (b_pend && b_wait > 0) begin
                b_wait <= b_wait - 1;
            end else if (b_pend && s_if.bready) begin
                b_pend <= 1'b0;
            end
        end
    end

    // ---------------- master drivers ----------------
    task automatic clear_masters();
        m0_if.araddr = 32'h0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b1;
        m0_if.awaddr = 32'h0; m0_if.awvalid = 1'b0; m0_if.wdata = 32'h0;
        m0_if.wstrb = 4'h0;   m0_if.wvalid = 1'b0;  m0_if.bready = 1'b0;
        m1_if.araddr = 32'h0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b1;
        m1_if.awaddr = 32'h0; m1_if.awvalid = 1'b0; m1_if.wdata = 32'h0;
        m1_if.wstrb = 4'h0;   m1_if.wvalid = 1'b0;  m1_if.bready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_masters();
        spur = 1'b0; rd_lat = 2; b_lat = 1;
        m0_reissue = 0; m1_reissue = 0;
        obs.delete(); exp_r0.delete(); exp_r1.delete(); exp_b.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: record what the DUT shows, then retire master requests that handshook.
    task automatic step();
        obs_t o;
        logic h_ar0, h_ar1, h_aw, h_w;
        @(negedge clk);
        o.g = grant;
        o.r0hs = m0_if.rvalid & m0_if.rready;   o.r0d = m0_if.rdata;
        o.r1hs = m1_if.rvalid & m1_if.rready;   o.r1d = m1_if.rdata;
        o.bhs  = m1_if.bvalid & m1_if.bready;   o.bresp = m1_if.bresp;
        o.m0_ar_rdy = m0_if.arready;
        o.s_arv = s_if.arvalid; o.s_awv = s_if.awvalid; o.s_wv = s_if.wvalid;
        h_ar0 = m0_if.arvalid & m0_if.arready;
        h_ar1 = m1_if.arvalid & m1_if.arready;
        h_aw  = m1_if.awvalid & m1_if.awready;
        h_w   = m1_if.wvalid & m1_if.wready;
        obs.push_back(o);
        @(posedge clk);
        #1;
        if (h_ar0) begin
            if (m0_reissue > 0) begin
                m0_reissue--;
                m0_if.araddr = m0_if.araddr + 32'd4;
                exp_r0.push_back(exp_rd(m0_if.araddr));
            end else m0_if.arvalid = 1'b0;
        end
        if (h_ar1) begin
            if (m1_reissue > 0) begin
                m1_reissue--;
                m1_if.araddr = m1_if.araddr + 32'd4;
                exp_r1.push_back(exp_rd(m1_if.araddr));
            end else m1_if.arvalid = 1'b0;
        end
        if (h_aw) m1_if.awvalid = 1'b0;
        if (h_w)  m1_if.wvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1; m1_if.awvalid = 1'b1; m1_if.wvalid = 1'b1;
        m1_if.wdata = 32'hFFFF_FFFF; m1_if.awaddr = 32'hFFFF_FFFF; m0_if.araddr = 32'hFFFF_FFFF;
        spur = 1'b1;
        #2;
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL reset_grant actual=%b required=00", grant);
        end
        checks++;
        if ({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_slave_ctrl actual=%b required=00000",
                     {s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready});
        end
        checks++;
        if ({m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, m1_if.awready,
             m1_if.wready, m1_if.bvalid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_master_ctrl actual=%b required=0000000",
                     {m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, m1_if.awready,
                      m1_if.wready, m1_if.bvalid});
        end
        checks++;
        if ({s_if.araddr, s_if.awaddr, s_if.wdata, s_if.wstrb} !== 100'b0) begin
            failures++;
            $display("FAIL reset_slave_data actual=%h/%h/%h/%h required=0",
                     s_if.araddr, s_if.awaddr, s_if.wdata, s_if.wstrb);
        end
        spur = 1'b0;
    endtask

    task automatic test_m0_single();
        int ri;
        int nr;
        do_reset();
        m0_if.araddr = 32'h8000_0000; m0_if.arvalid = 1'b1;
        exp_r0.push_back(32'h0000_0413);
        repeat (10) step();
        ri = -1; nr = 0;
        foreach (obs[i]) if (obs[i].r0hs) begin
            nr++;
            if (ri < 0) ri = i;
            checks++;
            if (exp_r0.size() == 0) begin
                failures++; $display("FAIL single_r0_extra actual=%h required=none", obs[i].r0d);
            end else if (obs[i].r0d !== exp_r0[0]) begin
                failures++; $display("FAIL single_r0_data actual=%h required=%h", obs[i].r0d, exp_r0[0]);
                void'(exp_r0.pop_front());
            end else void'(exp_r0.pop_front());
        end
        checks++;
        if (obs[0].g !== 2'b00 || obs[0].s_arv !== 1'b0) begin
            failures++; $display("FAIL single_idle_cycle actual=g%b/arv%b required=g00/arv0", obs[0].g, obs[0].s_arv);
        end
        checks++;
        if (obs[1].g !== 2'b01 || obs[1].s_arv !== 1'b1) begin
            failures++; $display("FAIL single_grant actual=g%b/arv%b required=g01/arv1", obs[1].g, obs[1].s_arv);
        end
        checks++;
        if (nr !== 1 || ri !== 4) begin
            failures++; $display("FAIL single_rvalid actual=count%0d@%0d required=count1@4", nr, ri);
        end
        checks++;
        if (obs[5].g !== 2'b00) begin
            failures++; $display("FAIL single_release actual=%b required=00", obs[5].g);
        end
        checks++;
        if (exp_r0.size() != 0) begin
            failures++; $display("FAIL single_missing actual=%0d required=0", exp_r0.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] seg[$];
        logic [1:0] prev;
        logic [1:0] want[4];
        logic [1:0] got;
        do_reset();
        rd_lat = 1;
        m0_if.araddr = 32'h8000_0000; m0_if.arvalid = 1'b1; m0_reissue = 1;
        m1_if.araddr = 32'h8000_0020; m1_if.arvalid = 1'b1; m1_reissue = 1;
        exp_r0.push_back(32'h0000_0413);
        exp_r1.push_back(32'hC0DE_0008);
        repeat (40) step();
        prev = 2'b00;
        foreach (obs[i]) begin
            if (obs[i].g != 2'b00 && obs[i].g != prev) seg.push_back(obs[i].g);
            prev = obs[i].g;
        end
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            got = (i < seg.size()) ? seg[i] : 2'bxx;
            checks++;
            if (got !== want[i]) begin
                failures++; $display("FAIL rr_grant_%0d actual=%b required=%b", i, got, want[i]);
            end
        end
        foreach (obs[i]) begin
            if (obs[i].r0hs) begin
                checks++;
                if (exp_r0.size() == 0 || obs[i].r0d !== exp_r0[0]) begin
                    failures++; $display("FAIL rr_r0_data actual=%h required=%h", obs[i].r0d,
                                         (exp_r0.size() == 0) ? 32'hx : exp_r0[0]);
                end
                if (exp_r0.size() != 0) void'(exp_r0.pop_front());
            end
            if (obs[i].r1hs) begin
                checks++;
                if (exp_r1.size() == 0 || obs[i].r1d !== exp_r1[0]) begin
                    failures++; $display("FAIL rr_r1_data actual=%h required=%h", obs[i].r1d,
                                         (exp_r1.size() == 0) ? 32'hx : exp_r1[0]);
                end
                if (exp_r1.size() != 0) void'(exp_r1.pop_front());
            end
        end
        checks++;
        if (exp_r0.size() + exp_r1.size() != 0) begin
            failures++; $display("FAIL rr_missing actual=%0d required=0", exp_r0.size() + exp_r1.size());
        end
    endtask

    task automatic test_write_then_read();
        logic [1:0] seg[$];
        logic [1:0] prev;
        int nb;
        do_reset();
        rd_lat = 1; b_lat = 1;
        m1_if.awaddr = 32'h8000_1000; m1_if.awvalid = 1'b1;
        m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF; m1_if.wvalid = 1'b1;
        m1_if.araddr = 32'h8000_1000; m1_if.arvalid = 1'b1;
        exp_b.push_back(2'b00);
        exp_r1.push_back(32'hDEAD_BEEF);
        repeat (30) step();
        prev = 2'b00; nb = 0;
        foreach (obs[i]) begin
            if (obs[i].g != 2'b00 && obs[i].g != prev) seg.push_back(obs[i].g);
            prev = obs[i].g;
            if (obs[i].bhs) begin
                nb++;
                checks++;
                if (exp_b.size() == 0 || obs[i].bresp !== exp_b[0]) begin
                    failures++; $display("FAIL wr_bresp actual=%b required=%b", obs[i].bresp,
                                         (exp_b.size() == 0) ? 2'bxx : exp_b[0]);
                end
                if (exp_b.size() != 0) void'(exp_b.pop_front());
            end
            if (obs[i].r1hs) begin
                checks++;
                if (exp_r1.size() == 0 || obs[i].r1d !== exp_r1[0]) begin
                    failures++; $display("FAIL wr_readback actual=%h required=%h", obs[i].r1d,
                                         (exp_r1.size() == 0) ? 32'hx : exp_r1[0]);
                end
                if (exp_r1.size() != 0) void'(exp_r1.pop_front());
            end
        end
        checks++;
        if (seg.size() != 2 || seg[0] !== 2'b11 || seg[1] !== 2'b10) begin
            failures++; $display("FAIL wr_order actual=%0d grants first=%b required=2 grants 11,10",
                                 seg.size(), (seg.size() > 0) ? seg[0] : 2'bxx);
        end
        checks++;
        if (nb != 1 || exp_r1.size() != 0) begin
            failures++; $display("FAIL wr_counts actual=b%0d/rleft%0d required=b1/rleft0", nb, exp_r1.size());
        end
    endtask

    task automatic test_w_before_aw();
        int nw, naw, iw, iaw, nb;
        do_reset();
        b_lat = 2; rd_lat = 1;
        m1_if.wdata = 32'h1234_5678; m1_if.wstrb = 4'b0011; m1_if.wvalid = 1'b1;
        repeat (3) step();
        m1_if.awaddr = 32'h8000_0008; m1_if.awvalid = 1'b1;
        exp_b.push_back(2'b00);
        repeat (12) step();
        m1_if.araddr = 32'h8000_0008; m1_if.arvalid = 1'b1;
        exp_r1.push_back(32'hC0DE_5678);
        repeat (10) step();
        nw = 0; naw = 0; iw = -1; iaw = -1; nb = 0;
        foreach (obs[i]) begin
            if (obs[i].s_wv)  begin nw++;  if (iw < 0)  iw = i;  end
            if (obs[i].s_awv) begin naw++; if (iaw < 0) iaw = i; end
            if (obs[i].bhs) begin
                nb++;
                checks++;
                if (exp_b.size() == 0 || obs[i].bresp !== exp_b[0]) begin
                    failures++; $display("FAIL wfirst_bresp actual=%b required=%b", obs[i].bresp,
                                         (exp_b.size() == 0) ? 2'bxx : exp_b[0]);
                end
                if (exp_b.size() != 0) void'(exp_b.pop_front());
            end
            if (obs[i].r1hs) begin
                checks++;
                if (exp_r1.size() == 0 || obs[i].r1d !== exp_r1[0]) begin
                    failures++; $display("FAIL wfirst_strb_readback actual=%h required=%h", obs[i].r1d,
                                         (exp_r1.size() == 0) ? 32'hx : exp_r1[0]);
                end
                if (exp_r1.size() != 0) void'(exp_r1.pop_front());
            end
        end
        checks++;
        if (nw != 1 || naw != 1 || nb != 1) begin
            failures++; $display("FAIL wfirst_counts actual=w%0d/aw%0d/b%0d required=w1/aw1/b1", nw, naw, nb);
        end
        checks++;
        if (!(iw >= 0 && iaw > iw)) begin
            failures++; $display("FAIL wfirst_order actual=w@%0d/aw@%0d required=w before aw", iw, iaw);
        end
        checks++;
        if (obs[obs.size()-1].g !== 2'b00 || exp_r1.size() != 0) begin
            failures++; $display("FAIL wfirst_idle actual=%b/rleft%0d required=00/rleft0",
                                 obs[obs.size()-1].g, exp_r1.size());
        end
    endtask

    task automatic test_hold_m0();
        int k, nrdy;
        do_reset();
        rd_lat = 8;
        m1_if.araddr = 32'h8000_0020; m1_if.arvalid = 1'b1;
        exp_r1.push_back(32'hC0DE_0008);
        step();
        m0_if.araddr = 32'h8000_0004; m0_if.arvalid = 1'b1;
        exp_r0.push_back(32'hC0DE_0001);
        repeat (30) step();
        k = -1;
        foreach (obs[i]) if (obs[i].r1hs && k < 0) k = i;
        checks++;
        if (k < 0 || k + 2 >= obs.size()) begin
            failures++; $display("FAIL hold_m1_resp actual=none required=one R handshake");
        end else begin
            nrdy = 0;
            for (int i = 0; i <= k + 1; i++) if (obs[i].m0_ar_rdy) nrdy++;
            if (obs[k].r1d !== exp_r1[0]) begin
                failures++; $display("FAIL hold_r1_data actual=%h required=%h", obs[k].r1d, exp_r1[0]);
            end
            checks++;
            if (nrdy != 0 || k < 10) begin
                failures++; $display("FAIL hold_m0_arready actual=%0d high cycles, k=%0d required=0 high, k>=10", nrdy, k);
            end
            checks++;
            if (obs[k+1].g !== 2'b00 || obs[k+2].g !== 2'b01) begin
                failures++; $display("FAIL hold_next_grant actual=%b,%b required=00,01", obs[k+1].g, obs[k+2].g);
            end
        end
        foreach (obs[i]) if (obs[i].r0hs) begin
            checks++;
            if (exp_r0.size() == 0 || obs[i].r0d !== exp_r0[0]) begin
                failures++; $display("FAIL hold_r0_data actual=%h required=%h", obs[i].r0d,
                                     (exp_r0.size() == 0) ? 32'hx : exp_r0[0]);
            end
            if (exp_r0.size() != 0) void'(exp_r0.pop_front());
        end
        checks++;
        if (exp_r0.size() != 0) begin
            failures++; $display("FAIL hold_m0_missing actual=%0d required=0", exp_r0.size());
        end
    endtask

    task automatic test_reset_mid_write();
        int naw, nb;
        do_reset();
        b_lat = 6;
        m1_if.awaddr = 32'h8000_0010; m1_if.awvalid = 1'b1;
        m1_if.wdata = 32'hCAFE_F00D; m1_if.wstrb = 4'hF; m1_if.wvalid = 1'b1;
        repeat (3) step();
        naw = 0;
        foreach (obs[i]) if (obs[i].s_awv) naw++;
        checks++;
        if (grant !== 2'b11 || naw != 1) begin
            failures++; $display("FAIL midrst_pre actual=g%b/aw%0d required=g11/aw1", grant, naw);
        end
        m1_if.awvalid = 1'b1; m1_if.wvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, s_if.awvalid, s_if.wvalid, s_if.bready, m1_if.bvalid, m1_if.awready, m1_if.wready} !== 8'b0) begin
            failures++;
            $display("FAIL midrst_outputs actual=%b required=00000000",
                     {grant, s_if.awvalid, s_if.wvalid, s_if.bready, m1_if.bvalid, m1_if.awready, m1_if.wready});
        end
        do_reset();
        m0_if.araddr = 32'h8000_0000; m0_if.arvalid = 1'b1;
        exp_r0.push_back(32'h0000_0413);
        repeat (14) step();
        nb = 0;
        foreach (obs[i]) begin
            if (obs[i].bhs) nb++;
            if (obs[i].r0hs) begin
                checks++;
                if (exp_r0.size() == 0 || obs[i].r0d !== exp_r0[0]) begin
                    failures++; $display("FAIL midrst_read actual=%h required=%h", obs[i].r0d,
                                         (exp_r0.size() == 0) ? 32'hx : exp_r0[0]);
                end
                if (exp_r0.size() != 0) void'(exp_r0.pop_front());
            end
        end
        checks++;
        if (nb != 0 || exp_r0.size() != 0) begin
            failures++; $display("FAIL midrst_after actual=b%0d/rleft%0d required=b0/rleft0", nb, exp_r0.size());
        end
    endtask

    task automatic test_spurious_resp();
        do_reset();
        spur = 1'b1;
        #1;
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid, m1_if.bvalid, s_if.rready, s_if.bready} !== 5'b0) begin
            failures++;
            $display("FAIL spurious_resp actual=%b required=00000",
                     {m0_if.rvalid, m1_if.rvalid, m1_if.bvalid, s_if.rready, s_if.bready});
        end
        spur = 1'b0;
    endtask

    initial begin
        clear_masters();
        test_reset();
        $display("test_reset done checks=%0d", checks);
        test_m0_single();
        $display("test_m0_single done checks=%0d", checks);
        test_round_robin();
        $display("test_round_robin done checks=%0d", checks);
        test_write_then_read();
        $display("test_write_then_read done checks=%0d", checks);
        test_w_before_aw();
        $display("test_w_before_aw done checks=%0d", checks);
        test_hold_m0();
        $display("test_hold_m0 done checks=%0d", checks);
        test_reset_mid_write();
        $display("test_reset_mid_write done checks=%0d", checks);
        test_spurious_resp();
        $display("test_spurious_resp done checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
